// File: rtl/rpm_setpoint_ramp.sv
// Per-channel RPM setpoint slew limiter.
// Captures signed target words from the command decoder and moves each channel's setpoint
// toward its target by at most STEP once every TICK_DIV clocks. This keeps command steps
// from reaching the PID loops and motors directly.
module rpm_setpoint_ramp #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_CHN    = 4,
  parameter int unsigned CHN_WIDTH  = 3,
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned STEP       = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tr_valid_i,
  input  logic [CHN_WIDTH-1:0]          tr_chn_i,
  input  logic [DATA_WIDTH-1:0]         tr_data_i,
  input  logic                          estop_i,
  output logic [NUM_CHN*DATA_WIDTH-1:0] sp_o,
  output logic [NUM_CHN-1:0]            sp_update_o,
  output logic [NUM_CHN-1:0]            busy_o,
  output logic                          chn_err_o
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);
  // STEP at the widened difference width, and at the setpoint width for add/subtract.
  localparam logic [DATA_WIDTH:0]   StepWide   = (DATA_WIDTH + 1)'(STEP);
  localparam logic [DATA_WIDTH-1:0] StepNarrow = DATA_WIDTH'(STEP);
  // One extra bit so NUM_CHN == 2^CHN_WIDTH is representable.
  localparam logic [CHN_WIDTH:0]    NumChnW    = (CHN_WIDTH + 1)'(NUM_CHN);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tick;
  logic            wr_en;
  logic            chn_err_q, chn_err_d;

  // Tick divider: wraps at TICK_DIV-1, forced to 0 by emergency stop.
  always_comb begin
    tick  = (cnt_q == CntMax);
    cnt_d = cnt_q + 1'b1;
    if (estop_i || tick) begin
      cnt_d = '0;
    end
  end

  // Word acceptance; out-of-range channels are dropped and flagged for one cycle.
  always_comb begin
    wr_en     = tr_valid_i && !estop_i;
    chn_err_d = wr_en && ({1'b0, tr_chn_i} >= NumChnW);
  end

  // Shared divider and error-pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      chn_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      chn_err_q <= chn_err_d;
    end
  end

  assign chn_err_o = chn_err_q;

  for (genvar i = 0; i < NUM_CHN; i++) begin : g_chn
    localparam logic [CHN_WIDTH-1:0] ChnIdx = CHN_WIDTH'(i);

    logic [DATA_WIDTH-1:0]      tgt_q, tgt_d;
    logic [DATA_WIDTH-1:0]      sp_q, sp_d;
    logic                       upd_q;
    logic signed [DATA_WIDTH:0] diff;
    logic [DATA_WIDTH:0]        mag;

    // Sign-extend by one bit so target - sp can never overflow.
    assign diff = $signed({tgt_q[DATA_WIDTH-1], tgt_q}) - $signed({sp_q[DATA_WIDTH-1], sp_q});
    assign mag  = diff[DATA_WIDTH] ? -diff : diff;

    // Target capture and slew step; the step looks at tgt_q, so a word landing on the
    // tick edge only takes effect from the following tick.
    always_comb begin
      tgt_d = tgt_q;
      sp_d  = sp_q;
      if (estop_i) begin
        tgt_d = '0;
        sp_d  = '0;
      end else begin
        if (wr_en && (tr_chn_i == ChnIdx)) begin
          tgt_d = tr_data_i;
        end
        if (tick) begin
          if (mag <= StepWide) begin
            sp_d = tgt_q;
          end else if (!diff[DATA_WIDTH]) begin
            sp_d = sp_q + StepNarrow;
          end else begin
            sp_d = sp_q - StepNarrow;
          end
        end
      end
    end

    // Channel state; the update flag marks a setpoint that changed on the previous edge.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        tgt_q <= '0;
        sp_q  <= '0;
        upd_q <= 1'b0;
      end else begin
        tgt_q <= tgt_d;
        sp_q  <= sp_d;
        upd_q <= (sp_d != sp_q);
      end
    end

    assign sp_o[i*DATA_WIDTH +: DATA_WIDTH] = sp_q;
    assign sp_update_o[i]                   = upd_q;
    assign busy_o[i]                        = (tgt_q != sp_q);
  end

endmodule

// File: tb/tb_rpm_setpoint_ramp.sv
// Self-checking bench for rpm_setpoint_ramp with TICK_DIV=4, STEP=8.
module tb_rpm_setpoint_ramp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tr_valid_i = 1'b0;
  logic [2:0]  tr_chn_i = '0;
  logic [15:0] tr_data_i = '0;
  logic        estop_i = 1'b0;
  logic [63:0] sp_o;
  logic [3:0]  sp_update_o;
  logic [3:0]  busy_o;
  logic        chn_err_o;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  int          ph;  // expected tick-counter value, tracked independently of the DUT

  rpm_setpoint_ramp #(
    .DATA_WIDTH(16),
    .NUM_CHN   (4),
    .CHN_WIDTH (3),
    .TICK_DIV  (4),
    .STEP      (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tr_valid_i (tr_valid_i),
    .tr_chn_i   (tr_chn_i),
    .tr_data_i  (tr_data_i),
    .estop_i    (estop_i),
    .sp_o       (sp_o),
    .sp_update_o(sp_update_o),
    .busy_o     (busy_o),
    .chn_err_o  (chn_err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst)          ph <= 0;
    else if (estop_i) ph <= 0;
    else              ph <= (ph + 1) % 4;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] sp_of(input int ch);
    return sp_o[ch*16 +: 16];
  endfunction

  // Called at a falling edge; returns at the falling edge after the capture edge.
  task automatic send_word(input logic [2:0] ch, input logic [15:0] d);
    tr_valid_i = 1'b1;
    tr_chn_i   = ch;
    tr_data_i  = d;
    @(negedge clk);
    tr_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (sp_o !== 64'h0 || busy_o !== 4'h0 || sp_update_o !== 4'h0 || chn_err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: sp=%h busy=%b upd=%b err=%b, want all 0",
               sp_o, busy_o, sp_update_o, chn_err_o);
    end
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (sp_o !== 64'h0 || busy_o !== 4'h0 || sp_update_o !== 4'h0) begin
        errors++;
        $display("FAIL reset_idle cyc%0d: sp=%h busy=%b upd=%b, want 0/0/0",
                 c, sp_o, busy_o, sp_update_o);
      end
    end
  endtask

  task automatic test_ramp_up();
    exp_q.push_back(16'd8);
    exp_q.push_back(16'd16);
    exp_q.push_back(16'd20);
    send_word(3'd1, 16'd20);
    checks++;
    if (busy_o[1] !== 1'b1) begin
      errors++;
      $display("FAIL ramp_busy_start: busy1=%b, want 1", busy_o[1]);
    end
    for (int c = 0; c < 30 && exp_q.size() != 0; c++) begin
      @(negedge clk);
      if (sp_update_o[1] === 1'b1) begin
        logic [15:0] e;
        e = exp_q.pop_front();
        checks++;
        if (sp_of(1) !== e || busy_o[1] !== (exp_q.size() != 0)) begin
          errors++;
          $display("FAIL ramp_step: sp1=%0d busy1=%b, want sp1=%0d busy1=%b",
                   sp_of(1), busy_o[1], e, exp_q.size() != 0);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL ramp_timeout: %0d steps missing, want 0", exp_q.size());
      exp_q.delete();
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (sp_update_o !== 4'h0 || sp_of(1) !== 16'd20) begin
        errors++;
        $display("FAIL ramp_settled: upd=%b sp1=%0d, want 0000 and 20", sp_update_o, sp_of(1));
      end
    end
  endtask

  task automatic test_neg_single();
    exp_q.push_back(16'hFFFD);
    send_word(3'd2, 16'hFFFD);
    for (int c = 0; c < 10 && exp_q.size() != 0; c++) begin
      @(negedge clk);
      if (sp_update_o !== 4'h0) begin
        logic [15:0] e;
        e = exp_q.pop_front();
        checks++;
        if (sp_update_o !== 4'b0100 || sp_o !== {16'h0, e, 16'd20, 16'h0} || busy_o !== 4'h0) begin
          errors++;
          $display("FAIL neg_step: upd=%b sp=%h busy=%b, want 0100 %h 0000",
                   sp_update_o, sp_o, busy_o, {16'h0, e, 16'd20, 16'h0});
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL neg_timeout: %0d steps missing, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_bad_chn();
    send_word(3'd5, 16'd100);
    checks++;
    if (chn_err_o !== 1'b1) begin
      errors++;
      $display("FAIL chn_err_pulse: err=%b, want 1", chn_err_o);
    end
    @(negedge clk);
    checks++;
    if (chn_err_o !== 1'b0) begin
      errors++;
      $display("FAIL chn_err_clear: err=%b, want 0", chn_err_o);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (sp_o !== {16'h0, 16'hFFFD, 16'd20, 16'h0} || busy_o !== 4'h0 ||
          sp_update_o !== 4'h0 || chn_err_o !== 1'b0) begin
        errors++;
        $display("FAIL chn_err_nochange: sp=%h busy=%b upd=%b err=%b, want %h 0000 0000 0",
                 sp_o, busy_o, sp_update_o, chn_err_o, {16'h0, 16'hFFFD, 16'd20, 16'h0});
      end
    end
  endtask

  task automatic test_tick_capture();
    for (int c = 0; c < 8 && ph != 3; c++) @(negedge clk);
    exp_q.push_back(16'd8);
    send_word(3'd0, 16'd100);
    checks++;
    if (sp_of(0) !== 16'd0 || sp_update_o[0] !== 1'b0 || busy_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL tick_capture_old: sp0=%0d upd0=%b busy0=%b, want 0 0 1",
               sp_of(0), sp_update_o[0], busy_o[0]);
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k < 4) begin
        checks++;
        if (sp_update_o[0] !== 1'b0 || sp_of(0) !== 16'd0) begin
          errors++;
          $display("FAIL tick_capture_wait%0d: upd0=%b sp0=%0d, want 0 0",
                   k, sp_update_o[0], sp_of(0));
        end
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        checks++;
        if (sp_update_o[0] !== 1'b1 || sp_of(0) !== e) begin
          errors++;
          $display("FAIL tick_capture_move: upd0=%b sp0=%0d, want 1 %0d",
                   sp_update_o[0], sp_of(0), e);
        end
      end
    end
  endtask

  task automatic test_estop();
    bit seen;
    seen = 1'b0;
    send_word(3'd3, 16'h7FFF);
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (sp_of(3) === 16'd16) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL estop_ramp_timeout: sp3=%0d, want 16", sp_of(3));
    end
    // Word offered during estop must be ignored.
    estop_i    = 1'b1;
    tr_valid_i = 1'b1;
    tr_chn_i   = 3'd3;
    tr_data_i  = 16'd50;
    @(negedge clk);
    estop_i    = 1'b0;
    tr_valid_i = 1'b0;
    checks++;
    if (sp_o !== 64'h0 || sp_update_o !== 4'hF || busy_o !== 4'h0) begin
      errors++;
      $display("FAIL estop_clear: sp=%h upd=%b busy=%b, want 0 1111 0000",
               sp_o, sp_update_o, busy_o);
    end
    // Counter restarted at 0: a word now moves sp on the 4th edge from here.
    exp_q.push_back(16'd4);
    send_word(3'd1, 16'd4);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k < 3) begin
        checks++;
        if (sp_update_o !== 4'h0) begin
          errors++;
          $display("FAIL estop_cnt_wait%0d: upd=%b, want 0000", k, sp_update_o);
        end
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        checks++;
        if (sp_update_o !== 4'b0010 || sp_o !== {16'h0, 16'h0, e, 16'h0}) begin
          errors++;
          $display("FAIL estop_cnt_move: upd=%b sp=%h, want 0010 %h",
                   sp_update_o, sp_o, {16'h0, 16'h0, e, 16'h0});
        end
      end
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (sp_update_o !== 4'h0 || sp_o !== {16'h0, 16'h0, 16'd4, 16'h0} || busy_o !== 4'h0) begin
        errors++;
        $display("FAIL estop_quiet: upd=%b sp=%h busy=%b, want 0000 %h 0000",
                 sp_update_o, sp_o, busy_o, {16'h0, 16'h0, 16'd4, 16'h0});
      end
    end
  endtask

  task automatic test_reset_midramp();
    bit seen;
    seen = 1'b0;
    send_word(3'd2, 16'd1000);
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (sp_update_o[2] === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || sp_of(2) !== 16'd8) begin
      errors++;
      $display("FAIL midramp_start: seen=%b sp2=%0d, want 1 8", seen, sp_of(2));
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (sp_o !== 64'h0 || sp_update_o !== 4'h0 || busy_o !== 4'h0) begin
      errors++;
      $display("FAIL midramp_async: sp=%h upd=%b busy=%b, want 0", sp_o, sp_update_o, busy_o);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (sp_o !== 64'h0 || busy_o !== 4'h0 || sp_update_o !== 4'h0) begin
        errors++;
        $display("FAIL midramp_no_stale: sp=%h busy=%b upd=%b, want 0",
                 sp_o, busy_o, sp_update_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_neg_single();
    test_bad_chn();
    test_tick_capture();
    test_estop();
    test_reset_midramp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
